hex_display_driver: RTL and testbench
=====================================

// Module: hex_display_driver
// PURPOSE
//  Registered, parametrised driver for N active-low seven-segment digits (DE1-SoC HEX style).
//  Captures a packed hex value on a load strobe and holds it between loads.
//  Adds optional leading-zero blanking and a per-digit blink mode.
//  Sits between the cursor/position logic and the board HEX pins.
// PARAMETERS
//  NUM_DIGITS  4           number of digits driven; digit 0 is least significant, 1..8 supported
//  BLINK_DIV   25_000_000  clock cycles per blink half-period, >=2
//  BLANK_LZ    1           1 = blank leading zero digits; digit 0 is never blanked
// PORTS
//  clock       in   1              system clock, rising edge
//  resetn      in   1              asynchronous active-low reset
//  load        in   1              capture value this cycle
//  value       in   4*NUM_DIGITS   packed nibbles, nibble i = digit i
//  blink_en    in   1              enable blink timing
//  blink_mask  in   NUM_DIGITS     digits that blank during the off phase
//  hex_out     out  7*NUM_DIGITS   segments {g..a} per digit, active-low; bits [7i+6:7i] = digit i
//  blink_phase out  1              1 = on phase, 0 = off phase
// BEHAVIOUR
//  Reset, asynchronous:
//   - value_q = 0, blink counter = 0, blink_phase = 1.
//   - hex_out = all 7'h7F, so every digit is dark.
//  Capture and latency:
//   - value_q <= value on any rising edge where load = 1.
//   - hex_out is a registered decode of value_q, blink_phase and blink_mask.
//   - A load sampled at edge N appears on hex_out after edge N+1, a latency of 2 clocks.
//   - A load held high re-captures every cycle. With no load, value_q holds.
//  Decode, segments gfedcba active-low:
//   - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
//   - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E
//   - blank = 7F
//  Leading-zero blank, when BLANK_LZ = 1:
//   - Digit i>0 is blanked when nibbles i..NUM_DIGITS-1 of value_q are all zero.
//   - Digit 0 always shows, so value 0 displays "0".
//  Blink counter and phase:
//   - When blink_en = 0: counter forced to 0 and blink_phase forced to 1 on the next edge.
//   - When blink_en = 1: counter runs 0..BLINK_DIV-1.
//   - On the wrap edge the counter returns to 0 and blink_phase toggles.
//  Blink blanking:
//   - When blink_phase = 0, digit i is blanked (7F) if blink_mask[i] = 1, else decoded normally.
//   - blink_mask is sampled combinationally into the hex_out register, with no extra delay.
//  Priority: blank (blink or LZ) overrides decode. LZ is evaluated on value_q, never on the raw value.
//  Simultaneous events:
//   - A load on the wrap edge updates value_q and toggles phase in the same edge.
//   - The next hex_out reflects both changes.
//  Reset mid-blink returns the block immediately to the reset state above.
//  Counter width: $clog2(BLINK_DIV). Comparison is against BLINK_DIV-1 only, with no overflow path.
// TESTING
//  1. Reset held, then released with no load -> hex_out = all 7F.
//     One edge later -> digit0 = 40, digits 3..1 = 7F (LZ=1).
//  2. load = 1 with value = 16'h1A3F at edge N -> hex_out = {79,08,30,0E} after edge N+1.
//     Before that edge, hex_out is unchanged.
//  3. value = 16'h0030, BLANK_LZ = 1 -> {7F,7F,30,40}.
//     Same value with BLANK_LZ = 0 -> {40,40,30,40}.
//  4. BLINK_DIV = 4, blink_en = 1, blink_mask = 4'b0011, value = 16'h1234:
//     - blink_phase toggles every 4 clocks.
//     - In the off phase, digits 1..0 = 7F and digits 3..2 = {79,24}.
//  5. blink_en dropped while in the off phase -> next edge gives phase = 1, counter = 0, all digits shown.
//     A load coincident with the wrap edge -> new value is shown with the toggled phase.
//  6. resetn asserted mid-count, asynchronously between edges -> hex_out = 7F and blink_phase = 1 at once.
//     value_q = 0 after release.

Source files
------------

// File: rtl/hex_display_driver.sv
// hex_display_driver: registered active-low seven-segment driver for NUM_DIGITS hex digits
// with leading-zero blanking and per-digit blink.
module hex_display_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    blink_en_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [7*NUM_DIGITS-1:0] hex_out_o,
    output logic                    blink_phase_o
);
    localparam int CW = $clog2(BLINK_DIV);

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    wrap;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h18;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    assign wrap = cnt_q == CW'(BLINK_DIV - 1);

    always_comb begin
        value_d = load_i ? value_i : value_q;
        cnt_d   = (!blink_en_i || wrap) ? '0 : cnt_q + 1'b1;
        phase_d = !blink_en_i ? 1'b1 : (wrap ? ~phase_q : phase_q);
    end

    // Decode works from registered state, giving the two-clock load-to-display latency.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic lz_blank;
        assign lz_blank = (BLANK_LZ != 0) && (i > 0) && (value_q[4*NUM_DIGITS-1:4*i] == '0);
        assign hex_d[7*i+:7] = (lz_blank || (!phase_q && blink_mask_i[i])) ? 7'h7F
                                                                          : seg(value_q[4*i+:4]);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            value_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            hex_q   <= '1;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hex_q   <= hex_d;
        end
    end

    assign hex_out_o     = hex_q;
    assign blink_phase_o = phase_q;
endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver: directed and random checks of hex_display_driver against an
// arithmetic display model (LZ on and LZ off instances share stimulus).
module tb_hex_display_driver;
    localparam int DIV = 4;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        load = 0;
    logic [15:0] value = 0;
    logic        blink_en = 0;
    logic [3:0]  blink_mask = 0;
    logic [27:0] hex_lz, hex_nolz;
    logic        phase_lz, phase_nolz;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] m_val;
    int          m_k;
    bit          m_ph;
    logic [27:0] m_hex, m_hex0;

    hex_display_driver #(.NUM_DIGITS(4), .BLINK_DIV(DIV), .BLANK_LZ(1)) dut (
        .clock_i(clk), .resetn_i(rst_n), .load_i(load), .value_i(value),
        .blink_en_i(blink_en), .blink_mask_i(blink_mask),
        .hex_out_o(hex_lz), .blink_phase_o(phase_lz)
    );

    hex_display_driver #(.NUM_DIGITS(4), .BLINK_DIV(DIV), .BLANK_LZ(0)) dut_nolz (
        .clock_i(clk), .resetn_i(rst_n), .load_i(load), .value_i(value),
        .blink_en_i(blink_en), .blink_mask_i(blink_mask),
        .hex_out_o(hex_nolz), .blink_phase_o(phase_nolz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected display for a held value, phase and mask.
    function automatic logic [27:0] disp(input logic [15:0] v, input bit ph,
                                         input logic [3:0] m, input bit lz);
        logic [27:0] d;
        for (int i = 0; i < 4; i++) begin
            bit show;
            show = !(lz && i > 0 && (v >> (4 * i)) == 0) && !(!ph && m[i]);
            d[7*i+:7] = show ? seg_t[(v >> (4 * i)) & 16'hF] : 7'h7F;
        end
        return d;
    endfunction

    task automatic model_reset();
        m_val = 0;
        m_k = 0;
        m_ph = 1;
        m_hex = '1;
        m_hex0 = '1;
    endtask

    task automatic step(input bit ld, input logic [15:0] v, input bit en, input logic [3:0] m);
        load = ld;
        value = v;
        blink_en = en;
        blink_mask = m;
        @(posedge clk);
        m_hex = disp(m_val, m_ph, m, 1);
        m_hex0 = disp(m_val, m_ph, m, 0);
        if (ld) m_val = v;
        m_k = en ? m_k + 1 : 0;
        m_ph = ((m_k / DIV) % 2) == 0;
        #1;
        check("hex_lz", 32'(hex_lz), 32'(m_hex));
        check("hex_nolz", 32'(hex_nolz), 32'(m_hex0));
        check("phase", 32'(phase_lz), 32'(m_ph));
        check("phase_nolz", 32'(phase_nolz), 32'(m_ph));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_hex", 32'(hex_lz), 32'h0FFF_FFFF);
        check("reset_phase", 32'(phase_lz), 32'd1);
        @(negedge clk);
        rst_n = 1;
        step(0, 16'h0000, 0, 4'h0);
        check("zero_disp", 32'(hex_lz), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        step(1, 16'h1A3F, 0, 4'h0);
        check("load_latency_hold", 32'(hex_lz), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        step(0, 16'h0000, 0, 4'h0);
        check("load_1A3F", 32'(hex_lz), 32'({7'h79, 7'h08, 7'h30, 7'h0E}));

        step(1, 16'h0030, 0, 4'h0);
        step(0, 16'h0000, 0, 4'h0);
        check("lz_0030", 32'(hex_lz), 32'({7'h7F, 7'h7F, 7'h30, 7'h40}));
        check("nolz_0030", 32'(hex_nolz), 32'({7'h40, 7'h40, 7'h30, 7'h40}));

        step(1, 16'h1234, 0, 4'b0011);
        for (int c = 0; c < 13; c++) begin
            step(0, 16'h0000, 1, 4'b0011);
            if (!m_ph && m_k % DIV == 1)
                check("blink_off", 32'(hex_lz), 32'({7'h79, 7'h24, 7'h7F, 7'h7F}));
        end
        while (m_ph) step(0, 16'h0000, 1, 4'b0011);
        step(0, 16'h0000, 0, 4'b0011);
        check("drop_en_phase", 32'(phase_lz), 32'd1);
        step(0, 16'h0000, 0, 4'b0011);
        check("drop_en_shown", 32'(hex_lz), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        for (int c = 0; c < DIV - 1; c++) step(0, 16'h0000, 1, 4'b1111);
        step(1, 16'hBEEF, 1, 4'b1111);
        check("wrap_load_phase", 32'(phase_lz), 32'd0);
        step(0, 16'h0000, 1, 4'b0100);
        check("wrap_load_hex", 32'(hex_lz), 32'({7'h03, 7'h7F, 7'h06, 7'h0E}));

        for (int c = 0; c < 400; c++) begin
            logic [15:0] msk;
            int r;
            r = $urandom_range(0, 3);
            msk = r == 0 ? 16'hFFFF : r == 1 ? 16'h00FF : r == 2 ? 16'h000F : 16'h0000;
            step($urandom_range(0, 2) == 0, 16'($urandom) & msk,
                 $urandom_range(0, 9) != 0, 4'($urandom));
        end

        step(1, 16'h4321, 1, 4'b1010);
        step(0, 16'h0000, 1, 4'b1010);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("async_rst_hex", 32'(hex_lz), 32'h0FFF_FFFF);
        check("async_rst_phase", 32'(phase_lz), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(0, 16'h0000, 0, 4'b0000);
        check("post_rst_val", 32'(hex_lz), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
